ad9866_rx_agc: RTL and testbench



---
 rtl/ad9866_pkg.sv | 30 +++
 rtl/ad9866_rx_agc.sv | 132 +++++++++++++
 tb/tb_ad9866_rx_agc.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9866_pkg.sv
// Shared types and helpers for the AD9866 RX gain path.
// Gain arithmetic is done one bit wider so steps saturate instead of wrapping.
package ad9866_pkg;

   localparam logic [5:0] CMD_ADDR_RXGAIN = 6'h0a;

   typedef logic [5:0] gain_t;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      MEASURE = 2'd1,
      EVAL    = 2'd2,
      REQ     = 2'd3
   } agc_state_t;

   function automatic gain_t gain_sub_sat(gain_t g, gain_t step, gain_t floor_g);
      logic signed [6:0] diff;
      diff = $signed({1'b0, g}) - $signed({1'b0, step});
      if (diff < $signed({1'b0, floor_g})) return floor_g;
      return diff[5:0];
   endfunction

   function automatic gain_t gain_add_sat(gain_t g, gain_t ceil_g);
      logic [6:0] sum;
      sum = {1'b0, g} + 7'd1;
      if (sum > {1'b0, ceil_g}) return ceil_g;
      return sum[5:0];
   endfunction

endpackage

// File: rtl/ad9866_rx_agc.sv
// AD9866 RX automatic gain control: windowed clip/good-level evaluation with
// attack/hold-release stepping, written back through the ad9866 command port.
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | copy host_gain into gain after reset, then request it
// MEASURE | count window cycles, track host_gain / ceiling, honour tx_en
// EVAL    | one-cycle decision on the sticky flags at window end
// REQ     | hold cmd_rqst with stable cmd_data until cmd_ack
module ad9866_rx_agc
   import ad9866_pkg::*;
#(
   parameter int WIN_W        = 16,
   parameter int HOLD_WINDOWS = 8,
   parameter int ATTACK_STEP  = 6,
   parameter int GAIN_MIN     = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        agc_en,
   input  logic [5:0]  host_gain,
   input  logic        tx_en,
   input  logic        rxclip,
   input  logic        rxgoodlvl,
   output logic        rxclrstatus,
   output logic [5:0]  cmd_addr,
   output logic [31:0] cmd_data,
   output logic        cmd_rqst,
   input  logic        cmd_ack,
   output logic [5:0]  gain
);

   localparam int                 HOLD_W    = $clog2(HOLD_WINDOWS + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_WINDOWS);
   localparam gain_t              STEP      = gain_t'(ATTACK_STEP);
   localparam gain_t              GMIN      = gain_t'(GAIN_MIN);

   agc_state_t          state, state_n;
   gain_t               gain_n;
   logic [WIN_W-1:0]    win_cnt, win_cnt_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n, hold_inc;
   logic                clr_n;
   logic                tx_en_d;

   assign cmd_addr = CMD_ADDR_RXGAIN;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOAD;
         gain        <= '0;
         win_cnt     <= '0;
         hold_cnt    <= '0;
         cmd_rqst    <= 1'b0;
         cmd_data    <= '0;
         rxclrstatus <= 1'b0;
         tx_en_d     <= 1'b0;
      end else begin
         state       <= state_n;
         gain        <= gain_n;
         win_cnt     <= win_cnt_n;
         hold_cnt    <= hold_cnt_n;
         rxclrstatus <= clr_n;
         tx_en_d     <= tx_en;
         cmd_rqst    <= (state_n == REQ);
         // latch the command word once on entry so it stays stable during the request
         if (state_n == REQ && state != REQ)
            cmd_data <= {25'd0, 1'b1, gain_n};
      end
   end

   always_comb begin
      state_n    = state;
      gain_n     = gain;
      win_cnt_n  = win_cnt;
      hold_cnt_n = hold_cnt;
      clr_n      = 1'b0;
      hold_inc   = hold_cnt + 1'b1;
      case (state)
         LOAD: begin
            gain_n  = host_gain;
            state_n = REQ;
         end
         MEASURE: begin
            if (!agc_en && host_gain != gain) begin
               gain_n  = host_gain;
               state_n = REQ;
            end else if (agc_en && host_gain < gain) begin
               gain_n     = host_gain;
               hold_cnt_n = '0;
               state_n    = REQ;
            end else if (tx_en_d && !tx_en) begin
               // drop whatever the flags caught while transmitting
               win_cnt_n = '0;
               clr_n     = 1'b1;
            end else if (!tx_en) begin
               win_cnt_n = win_cnt + 1'b1;
               if (agc_en && (&win_cnt))
                  state_n = EVAL;
            end
         end
         EVAL: begin
            if (rxclip) begin
               gain_n     = gain_sub_sat(gain, STEP, GMIN);
               hold_cnt_n = '0;
            end else if (rxgoodlvl) begin
               hold_cnt_n = '0;
            end else if (hold_inc == HOLD_LAST) begin
               gain_n     = gain_add_sat(gain, host_gain);
               hold_cnt_n = '0;
            end else begin
               hold_cnt_n = hold_inc;
            end
            if (gain_n != gain) begin
               state_n = REQ;
            end else begin
               state_n   = MEASURE;
               clr_n     = 1'b1;
               win_cnt_n = '0;
            end
         end
         REQ: begin
            if (cmd_ack) begin
               state_n   = MEASURE;
               clr_n     = 1'b1;
               win_cnt_n = '0;
            end
         end
         default: state_n = LOAD;
      endcase
   end

endmodule

// File: tb/tb_ad9866_rx_agc.sv
// Self-checking bench for ad9866_rx_agc with short windows and an ack
// responder; expected gain sequences come from plain arithmetic on the rules.
module tb_ad9866_rx_agc;

   localparam int WIN_W        = 4;
   localparam int HOLD_WINDOWS = 2;
   localparam int ATTACK_STEP  = 6;
   localparam int GAIN_MIN     = 0;
   localparam int WIN_LEN      = 1 << WIN_W;
   localparam int EVAL_PERIOD  = WIN_LEN + 1;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        agc_en    = 1'b0;
   logic [5:0]  host_gain = 6'd40;
   logic        tx_en     = 1'b0;
   logic        rxclip    = 1'b0;
   logic        rxgoodlvl = 1'b0;
   logic        cmd_ack   = 1'b0;
   logic        rxclrstatus;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_rqst;
   logic [5:0]  gain;

   ad9866_rx_agc #(
      .WIN_W(WIN_W), .HOLD_WINDOWS(HOLD_WINDOWS),
      .ATTACK_STEP(ATTACK_STEP), .GAIN_MIN(GAIN_MIN)
   ) dut (
      .clk(clk), .rst(rst), .agc_en(agc_en), .host_gain(host_gain),
      .tx_en(tx_en), .rxclip(rxclip), .rxgoodlvl(rxgoodlvl),
      .rxclrstatus(rxclrstatus), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_rqst(cmd_rqst), .cmd_ack(cmd_ack), .gain(gain)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int proto_err = 0;
   int ack_dly   = 2;
   bit ack_en    = 1'b1;
   int cur_c     = 0;
   int cur_h     = 0;

   logic [31:0] req_data[$];
   int          req_cyc[$];
   int          clr_cyc[$];
   logic        rq_prev   = 1'b0;
   logic        clr_prev  = 1'b0;
   logic [31:0] data_prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmd_rqst && !rq_prev) begin
         req_data.push_back(cmd_data);
         req_cyc.push_back(cyc);
      end
      if (rxclrstatus) clr_cyc.push_back(cyc);
      if ((cmd_rqst && rq_prev && cmd_data != data_prev) || (rxclrstatus && clr_prev) ||
          cmd_addr != 6'h0a)
         proto_err <= proto_err + 1;
      rq_prev   <= cmd_rqst;
      clr_prev  <= rxclrstatus;
      data_prev <= cmd_data;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ack_en && cmd_rqst && !cmd_ack) begin
            repeat (ack_dly) @(negedge clk);
            cmd_ack = 1'b1;
            @(negedge clk);
            cmd_ack = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_cmd(int g);
      return {25'd0, 1'b1, 6'(g)};
   endfunction

   function automatic int count_clr(int lo, int hi);
      int n = 0;
      foreach (clr_cyc[i]) if (clr_cyc[i] >= lo && clr_cyc[i] <= hi) n++;
      return n;
   endfunction

   function automatic int count_req(int lo, int hi);
      int n = 0;
      foreach (req_cyc[i]) if (req_cyc[i] >= lo && req_cyc[i] <= hi) n++;
      return n;
   endfunction

   function automatic logic [31:0] req_at(int k);
      if (k < req_data.size()) return req_data[k];
      return '0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      req_data.delete();
      req_cyc.delete();
      clr_cyc.delete();
   endtask

   task automatic wait_reqs(input int n, input int budget);
      int k = 0;
      while (req_data.size() < n && k < budget) begin
         tick(1);
         k++;
      end
   endtask

   task automatic wait_quiet();
      int k = 0;
      while ((cmd_rqst || cmd_ack) && k < 50) begin
         tick(1);
         k++;
      end
      tick(2);
   endtask

   task automatic wait_rqst_high();
      int k = 0;
      while (!cmd_rqst && k < 20) begin
         tick(1);
         k++;
      end
   endtask

   task automatic test_reset();
      int exp_clr;
      rst = 1'b1; agc_en = 1'b0; host_gain = 6'd40; tx_en = 1'b0;
      rxclip = 1'b0; rxgoodlvl = 1'b0; ack_en = 1'b1; ack_dly = 2;
      tick(3);
      n_checks++; if (gain !== 6'd0) begin n_fail++; $display("FAIL reset_gain: got %0d want 0", gain); end
      n_checks++; if (cmd_rqst !== 1'b0) begin n_fail++; $display("FAIL reset_rqst: got %b want 0", cmd_rqst); end
      n_checks++; if (cmd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", cmd_data); end
      n_checks++; if (rxclrstatus !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b want 0", rxclrstatus); end
      n_checks++; if (cmd_addr !== 6'h0a) begin n_fail++; $display("FAIL reset_addr: got %h want 0a", cmd_addr); end
      clear_log();
      rst = 1'b0;
      wait_reqs(1, 20);
      tick(6);
      n_checks++; if (req_data.size() != 1) begin n_fail++; $display("FAIL load_req_count: got %0d want 1", req_data.size()); end
      n_checks++; if (req_at(0) !== 32'h68) begin n_fail++; $display("FAIL load_req_data: got %h want 68", req_at(0)); end
      n_checks++; if (gain !== 6'd40) begin n_fail++; $display("FAIL load_gain: got %0d want 40", gain); end
      exp_clr = (req_cyc.size() > 0) ? req_cyc[0] + ack_dly + 1 : -1;
      n_checks++;
      if (count_clr(exp_clr, exp_clr) != 1 || clr_cyc.size() != 1) begin
         n_fail++;
         $display("FAIL load_clr: got %0d pulses want one at cycle %0d", clr_cyc.size(), exp_clr);
      end
   endtask

   task automatic test_manual();
      int h, c0, lat;
      agc_en = 1'b0; rxclip = 1'b1;
      for (int i = 0; i < 4; i++) begin
         h = int'(host_gain);
         while (h == int'(host_gain)) h = $urandom_range(0, 63);
         clear_log();
         c0 = cyc;
         host_gain = 6'(h);
         wait_reqs(1, 10);
         tick(3 * WIN_LEN);
         lat = (req_cyc.size() > 0) ? req_cyc[0] - c0 : -1;
         n_checks++; if (req_data.size() != 1) begin n_fail++; $display("FAIL manual_count: got %0d want 1", req_data.size()); end
         n_checks++; if (req_at(0) !== exp_cmd(h)) begin n_fail++; $display("FAIL manual_data: got %h want %h", req_at(0), exp_cmd(h)); end
         n_checks++; if (lat < 1 || lat > 2) begin n_fail++; $display("FAIL manual_latency: got %0d want 1..2", lat); end
         n_checks++; if (gain !== 6'(h)) begin n_fail++; $display("FAIL manual_gain: got %0d want %0d", gain, h); end
      end
      rxclip = 1'b0;
   endtask

   task automatic test_attack();
      int h, g, n, gap;
      int exp_g[$];
      h = $urandom_range(20, 63);
      agc_en = 1'b0; rxclip = 1'b0; host_gain = 6'(h);
      tick(3);
      wait_quiet();
      g = h;
      while (g > GAIN_MIN) begin
         g = (g - ATTACK_STEP < GAIN_MIN) ? GAIN_MIN : g - ATTACK_STEP;
         exp_g.push_back(g);
      end
      n = exp_g.size();
      clear_log();
      agc_en = 1'b1; rxclip = 1'b1;
      wait_reqs(n, (n + 1) * (WIN_LEN + 8));
      tick(3 * EVAL_PERIOD + 5);
      n_checks++; if (req_data.size() != n) begin n_fail++; $display("FAIL attack_count: got %0d want %0d", req_data.size(), n); end
      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (req_at(k) !== exp_cmd(exp_g[k])) begin
            n_fail++;
            $display("FAIL attack_step%0d: got %h want %h", k, req_at(k), exp_cmd(exp_g[k]));
         end
      end
      for (int k = 1; k < n; k++) begin
         gap = (k < req_cyc.size()) ? req_cyc[k] - req_cyc[k-1] : -1;
         n_checks++;
         if (gap != EVAL_PERIOD + ack_dly + 1) begin
            n_fail++;
            $display("FAIL attack_gap%0d: got %0d want %0d", k, gap, EVAL_PERIOD + ack_dly + 1);
         end
      end
      n_checks++; if (gain !== 6'(GAIN_MIN)) begin n_fail++; $display("FAIL attack_floor: got %0d want %0d", gain, GAIN_MIN); end
      rxclip = 1'b0;
   endtask

   task automatic test_release();
      int g0, c, n, gap, exp_gap;
      g0 = $urandom_range(4, 59);
      c  = g0 + $urandom_range(1, 3);
      agc_en = 1'b0; host_gain = 6'(g0);
      tick(3);
      wait_quiet();
      n = c - g0;
      exp_gap = HOLD_WINDOWS * EVAL_PERIOD + ack_dly + 1;
      clear_log();
      agc_en = 1'b1; host_gain = 6'(c);
      wait_reqs(n, (n + 1) * 45);
      tick(4 * EVAL_PERIOD);
      n_checks++; if (req_data.size() != n) begin n_fail++; $display("FAIL release_count: got %0d want %0d", req_data.size(), n); end
      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (req_at(k) !== exp_cmd(g0 + k + 1)) begin
            n_fail++;
            $display("FAIL release_step%0d: got %h want %h", k, req_at(k), exp_cmd(g0 + k + 1));
         end
      end
      for (int k = 1; k < n; k++) begin
         gap = (k < req_cyc.size()) ? req_cyc[k] - req_cyc[k-1] : -1;
         n_checks++;
         if (gap != exp_gap) begin n_fail++; $display("FAIL release_gap%0d: got %0d want %0d", k, gap, exp_gap); end
      end
      n_checks++; if (gain !== 6'(c)) begin n_fail++; $display("FAIL release_ceiling: got %0d want %0d", gain, c); end
      cur_c = c;
   endtask

   task automatic test_ceiling();
      int h, c0, lat;
      h = $urandom_range(1, cur_c - 1);
      clear_log();
      c0 = cyc;
      host_gain = 6'(h);
      wait_reqs(1, 10);
      tick(3);
      wait_quiet();
      tick(2 * EVAL_PERIOD);
      lat = (req_cyc.size() > 0) ? req_cyc[0] - c0 : -1;
      n_checks++; if (req_data.size() != 1) begin n_fail++; $display("FAIL ceiling_count: got %0d want 1", req_data.size()); end
      n_checks++; if (req_at(0) !== exp_cmd(h)) begin n_fail++; $display("FAIL ceiling_data: got %h want %h", req_at(0), exp_cmd(h)); end
      n_checks++; if (lat < 1 || lat > 2) begin n_fail++; $display("FAIL ceiling_latency: got %0d want 1..2", lat); end
      n_checks++; if (gain !== 6'(h)) begin n_fail++; $display("FAIL ceiling_gain: got %0d want %0d", gain, h); end
      cur_h = h;
   endtask

   task automatic test_goodlvl();
      int g_exp;
      rxgoodlvl = 1'b1; host_gain = 6'd63;
      clear_log();
      tick(5 * EVAL_PERIOD);
      n_checks++; if (req_data.size() != 0) begin n_fail++; $display("FAIL good_no_req: got %0d want 0", req_data.size()); end
      n_checks++; if (gain !== 6'(cur_h)) begin n_fail++; $display("FAIL good_gain: got %0d want %0d", gain, cur_h); end
      n_checks++; if (clr_cyc.size() < 4) begin n_fail++; $display("FAIL good_windows: got %0d clears want >=4", clr_cyc.size()); end
      g_exp = (cur_h - ATTACK_STEP < GAIN_MIN) ? GAIN_MIN : cur_h - ATTACK_STEP;
      clear_log();
      rxclip = 1'b1;
      wait_reqs(1, 2 * EVAL_PERIOD + 10);
      rxclip = 1'b0;
      wait_quiet();
      n_checks++; if (req_data.size() != 1) begin n_fail++; $display("FAIL both_count: got %0d want 1", req_data.size()); end
      n_checks++; if (req_at(0) !== exp_cmd(g_exp)) begin n_fail++; $display("FAIL both_clip_wins: got %h want %h", req_at(0), exp_cmd(g_exp)); end
      n_checks++; if (gain !== 6'(g_exp)) begin n_fail++; $display("FAIL both_gain: got %0d want %0d", gain, g_exp); end
   endtask

   task automatic test_tx_freeze();
      int k, t_rise, t_fall;
      rxgoodlvl = 1'b1; rxclip = 1'b0; agc_en = 1'b1;
      k = 0;
      while (!rxclrstatus && k < 3 * EVAL_PERIOD) begin tick(1); k++; end
      tick(5);
      t_rise = cyc;
      tx_en = 1'b1;
      tick(50);
      t_fall = cyc;
      tx_en = 1'b0;
      tick(2 * EVAL_PERIOD + 5);
      n_checks++; if (count_clr(t_rise + 1, t_fall) != 0) begin n_fail++; $display("FAIL tx_frozen: got %0d clears during tx want 0", count_clr(t_rise + 1, t_fall)); end
      n_checks++; if (count_req(t_rise, cyc) != 0) begin n_fail++; $display("FAIL tx_no_req: got %0d want 0", count_req(t_rise, cyc)); end
      n_checks++; if (count_clr(t_fall + 1, t_fall + 1) != 1) begin n_fail++; $display("FAIL tx_fall_clr: got %0d want 1", count_clr(t_fall + 1, t_fall + 1)); end
      n_checks++; if (count_clr(t_fall + 2, t_fall + EVAL_PERIOD) != 0) begin n_fail++; $display("FAIL tx_window_clean: got %0d want 0", count_clr(t_fall + 2, t_fall + EVAL_PERIOD)); end
      n_checks++;
      if (count_clr(t_fall + EVAL_PERIOD + 1, t_fall + EVAL_PERIOD + 1) != 1) begin
         n_fail++;
         $display("FAIL tx_next_eval: got %0d want 1 at +%0d", count_clr(t_fall + EVAL_PERIOD + 1, t_fall + EVAL_PERIOD + 1), EVAL_PERIOD + 1);
      end
   endtask

   task automatic test_back_to_back();
      int h1, h2;
      agc_en = 1'b0; rxgoodlvl = 1'b0;
      tick(4);
      wait_quiet();
      ack_dly = 0;
      h1 = int'(host_gain);
      while (h1 == int'(host_gain)) h1 = $urandom_range(0, 63);
      host_gain = 6'(h1);
      wait_rqst_high();
      n_checks++; if (cmd_data !== exp_cmd(h1)) begin n_fail++; $display("FAIL b2b_data1: got %h want %h", cmd_data, exp_cmd(h1)); end
      tick(1);
      n_checks++; if (cmd_rqst !== 1'b0) begin n_fail++; $display("FAIL b2b_zero_wait: got %b want 0", cmd_rqst); end
      n_checks++; if (rxclrstatus !== 1'b1) begin n_fail++; $display("FAIL b2b_clr: got %b want 1", rxclrstatus); end
      h2 = h1;
      while (h2 == h1) h2 = $urandom_range(0, 63);
      host_gain = 6'(h2);
      wait_rqst_high();
      n_checks++; if (cmd_data !== exp_cmd(h2)) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", cmd_data, exp_cmd(h2)); end
      tick(1);
      n_checks++; if (cmd_rqst !== 1'b0) begin n_fail++; $display("FAIL b2b_drop2: got %b want 0", cmd_rqst); end
      n_checks++; if (gain !== 6'(h2)) begin n_fail++; $display("FAIL b2b_gain: got %0d want %0d", gain, h2); end
      tick(3);
      ack_dly = 2;
   endtask

   task automatic test_reset_in_req();
      int h, h2;
      ack_en = 1'b0;
      h = int'(host_gain);
      while (h == int'(host_gain)) h = $urandom_range(0, 63);
      host_gain = 6'(h);
      wait_rqst_high();
      tick(1);
      n_checks++; if (cmd_rqst !== 1'b1) begin n_fail++; $display("FAIL rreq_pending: got %b want 1", cmd_rqst); end
      rst = 1'b1;
      tick(1);
      n_checks++; if (cmd_rqst !== 1'b0) begin n_fail++; $display("FAIL rreq_drop: got %b want 0", cmd_rqst); end
      n_checks++; if (gain !== 6'd0) begin n_fail++; $display("FAIL rreq_gain_rst: got %0d want 0", gain); end
      h2 = $urandom_range(0, 63);
      host_gain = 6'(h2);
      ack_en = 1'b1;
      clear_log();
      rst = 1'b0;
      wait_reqs(1, 10);
      tick(3);
      wait_quiet();
      n_checks++; if (req_data.size() != 1) begin n_fail++; $display("FAIL rreq_count: got %0d want 1", req_data.size()); end
      n_checks++; if (req_at(0) !== exp_cmd(h2)) begin n_fail++; $display("FAIL rreq_reissue: got %h want %h", req_at(0), exp_cmd(h2)); end
      n_checks++; if (gain !== 6'(h2)) begin n_fail++; $display("FAIL rreq_gain: got %0d want %0d", gain, h2); end
   endtask

   task automatic test_protocol();
      n_checks++;
      if (proto_err != 0) begin
         n_fail++;
         $display("FAIL protocol: got %0d violations (data change/clr width/addr) want 0", proto_err);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_attack();
      test_release();
      test_ceiling();
      test_goodlvl();
      test_tx_freeze();
      test_back_to_back();
      test_reset_in_req();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
